// File: rtl/vga_scan_timing.sv
// VGA raster timing: DrawX/DrawY scan counters at Clk/2, one-pixel registered sync/blank/colour.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Red,
  input  logic [7:0]  Green,
  input  logic [7:0]  Blue,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        pixel_clk,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast    = 10'(HTotal - 1);
  localparam logic [9:0] VLast    = 10'(VTotal - 1);
  localparam logic [9:0] HVis     = 10'(H_VISIBLE);
  localparam logic [9:0] VVis     = 10'(V_VISIBLE);
  localparam logic [9:0] HsFirst  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HsLast   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VsLast   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       pix_en_q;
  logic [9:0] x_q, y_q;
  logic       hs_q, vs_q, de_q, fs_q;
  logic [7:0] r_q, g_q, b_q;

  logic x_wrap, y_wrap, hs0, vs0, de0;

  always_comb begin
    x_wrap = (x_q == HLast);
    y_wrap = (y_q == VLast);
    hs0    = !((x_q >= HsFirst) && (x_q <= HsLast));
    vs0    = !((y_q >= VsFirst) && (y_q <= VsLast));
    de0    = (x_q < HVis) && (y_q < VVis);
  end

  // Counters and the pin stage both move only on pix_en, so pins trail DrawX/DrawY by one pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= ~pix_en_q;
      fs_q     <= pix_en_q && x_wrap && y_wrap;
      if (pix_en_q) begin
        if (x_wrap) begin
          x_q <= '0;
          y_q <= y_wrap ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
        hs_q <= hs0;
        vs_q <= vs0;
        de_q <= de0;
        r_q  <= de0 ? Red   : 8'h00;
        g_q  <= de0 ? Green : 8'h00;
        b_q  <= de0 ? Blue  : 8'h00;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_q <= '0;
    end else if (pix_en_q && x_wrap && y_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign pixel_clk   = pix_en_q;
  assign frame_start = fs_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = de_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: full 800-pixel lines with a shortened frame (6 lines)
// so whole-frame behaviour fits a short run.
module tb_vga_scan_timing;

  localparam int VVis  = 2;
  localparam int VFp   = 1;
  localparam int VSync = 2;
  localparam int VBp   = 1;
  localparam int VTot  = VVis + VFp + VSync + VBp;
  localparam int HTot  = 800;
  localparam int FrameClk = HTot * VTot * 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       align_mode = 1'b0;
  logic [7:0] red, green, blue;
  logic [9:0] draw_x, draw_y;
  logic       pixel_clk, frame_start, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_scan_timing #(
    .V_VISIBLE (VVis),
    .V_FP      (VFp),
    .V_SYNC    (VSync),
    .V_BP      (VBp)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Red         (red),
    .Green       (green),
    .Blue        (blue),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pixel_clk   (pixel_clk),
    .frame_start (frame_start),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Mapper stand-in: constant colour, or red = DrawX[7:0] for alignment.
  always_comb begin
    red   = align_mode ? draw_x[7:0] : 8'hFF;
    green = 8'h55;
    blue  = 8'h00;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel monitor state; reference model of the counters and of the pin stage.
  logic mon_en = 1'b0;
  int ex_x, ex_y, prev_x, prev_y;
  logic prev_valid;
  int clk_cnt, n_pix, coord_err, pin_err;
  int hs_low, hs_first, hs_last, vs_low, vs_first, vs_last, vis_ok, last_vis_r;
  int fs_high, fs_rise, fs_first, fs_period, fs_prev_t;
  logic fs_last;

  task automatic clear_stats();
    ex_x = 0; ex_y = 0; prev_x = 0; prev_y = 0; prev_valid = 1'b0;
    clk_cnt = 0; n_pix = 0; coord_err = 0; pin_err = 0;
    hs_low = 0; hs_first = -1; hs_last = -1;
    vs_low = 0; vs_first = -1; vs_last = -1;
    vis_ok = 0; last_vis_r = -1;
    fs_high = 0; fs_rise = 0; fs_first = 0; fs_period = 0; fs_prev_t = 0; fs_last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic       e_hs, e_vs, e_de;
      logic [7:0] e_r, e_g;
      clk_cnt++;
      if (frame_start) begin
        fs_high++;
        if (!fs_last) begin
          fs_rise++;
          if (fs_first == 0) fs_first = clk_cnt;
          else if (fs_period == 0) fs_period = clk_cnt - fs_prev_t;
          fs_prev_t = clk_cnt;
        end
      end
      fs_last = frame_start;
      if (pixel_clk) begin
        n_pix++;
        if (int'(draw_x) != ex_x || int'(draw_y) != ex_y) coord_err++;
        if (!prev_valid) begin
          e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_r = 8'h00; e_g = 8'h00;
        end else begin
          e_de = (prev_x < 640) && (prev_y < VVis);
          e_hs = !(prev_x >= 656 && prev_x <= 751);
          e_vs = !(prev_y >= VVis + VFp && prev_y <= VVis + VFp + VSync - 1);
          e_r  = !e_de ? 8'h00 : (align_mode ? 8'(prev_x) : 8'hFF);
          e_g  = e_de ? 8'h55 : 8'h00;
        end
        if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !==
            {e_hs, e_vs, e_de, e_r, e_g, 8'h00}) pin_err++;
        if (!vga_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = prev_x;
          hs_last = prev_x;
        end
        if (!vga_vs) begin
          vs_low++;
          if (vs_first < 0) vs_first = prev_y;
          vs_last = prev_y;
        end
        if (vga_blank_n && vga_r == 8'hFF && vga_g == 8'h55 && vga_b == 8'h00) vis_ok++;
        if (vga_blank_n) last_vis_r = int'(vga_r);
        prev_x = ex_x; prev_y = ex_y; prev_valid = 1'b1;
        if (ex_x == HTot - 1) begin
          ex_x = 0;
          ex_y = (ex_y == VTot - 1) ? 0 : ex_y + 1;
        end else begin
          ex_x++;
        end
      end
    end
  end

  initial begin
    bit found;
    clear_stats();
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_hs", {31'd0, vga_hs}, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rst_xy", {draw_y, draw_x}, 0);
      check_eq("rst_sync", {vga_hs, vga_vs, vga_blank_n}, 3'b110);
      check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      check_eq("rst_pix_fs", {pixel_clk, frame_start}, 0);
    end
`ifdef VGA_FRAME_CNT_EN
    check_eq("rst_frame_cnt", frame_cnt, 0);
`endif

    // Phase A: constant colour, two frames.
    rst_n = 1'b1;
    #1 clear_stats();
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rel_first_x", draw_x, 0);
    check_eq("rel_first_pix", pixel_clk, 1);
    @(negedge clk);
    check_eq("rel_adv_x", draw_x, 1);
    check_eq("rel_adv_pix", pixel_clk, 0);
    repeat (1598) @(negedge clk);
    #1;
    check_eq("line_pix_highs", n_pix, 800);
    check_eq("line_wrap_x", draw_x, 0);
    check_eq("line_wrap_y", draw_y, 1);
    check_eq("line_hs_low", hs_low, 96);
    check_eq("line_hs_first", hs_first, 656);
    check_eq("line_hs_last", hs_last, 751);
    check_eq("line_no_fs", fs_high, 0);
    repeat (2 * FrameClk - 1600) @(negedge clk);
    #1;
    check_eq("frm_coord_err", coord_err, 0);
    check_eq("frm_pin_err", pin_err, 0);
    check_eq("frm_pix", n_pix, 2 * HTot * VTot);
    check_eq("frm_hs_low", hs_low, 2 * VTot * 96);
    check_eq("frm_vs_low", vs_low, 2 * VSync * HTot);
    check_eq("frm_vs_first", vs_first, VVis + VFp);
    check_eq("frm_vs_last", vs_last, VVis + VFp + VSync - 1);
    check_eq("frm_vis_ok", vis_ok, 2 * VVis * 640);
    check_eq("frm_fs_first", fs_first, FrameClk);
    check_eq("frm_fs_period", fs_period, FrameClk);
    check_eq("frm_fs_rise", fs_rise, 2);
    check_eq("frm_fs_width", fs_high, 2);
`ifdef VGA_FRAME_CNT_EN
    check_eq("frm_frame_cnt", frame_cnt, 2);
`endif

    // Reset in the middle of a sync pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * FrameClk && !found; i++) begin
      @(negedge clk);
      if (draw_x == 10'd700 && draw_y == 10'(VVis + VFp + 1)) found = 1'b1;
    end
    check_eq("midsync_found", {31'd0, found}, 1);
    check_eq("midsync_pre", {vga_hs, vga_vs}, 2'b00);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midsync_sync", {vga_hs, vga_vs}, 2'b11);
    check_eq("midsync_xy", {draw_y, draw_x}, 0);
    check_eq("midsync_blank", vga_blank_n, 0);
`ifdef VGA_FRAME_CNT_EN
    check_eq("midsync_frame_cnt", frame_cnt, 0);
`endif

    // Phase B: red follows DrawX, one frame.
    align_mode = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 clear_stats();
    mon_en = 1'b1;
    repeat (FrameClk + 2) @(negedge clk);
    #1;
    check_eq("aln_coord_err", coord_err, 0);
    check_eq("aln_pin_err", pin_err, 0);
    check_eq("aln_last_vis_r", last_vis_r, 8'h7F);
    check_eq("aln_fs_first", fs_first, FrameClk);
`ifdef VGA_FRAME_CNT_EN
    check_eq("aln_frame_cnt", frame_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
